pipe_skid_stage: RTL and testbench

- Parametrised pipeline stage register; successor to the fixed-field EX→MEM latch.
- Carries an opaque payload of DATA_W bits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake and a 2-entry skid buffer, so the upstream ready path is registered.
- Keeps the staller-driven hold (stall) and flush (bubble) controls; the flush inserts NOP_VALUE.

---
 rtl/pipe_skid_stage.sv | 142 ++++++++++++++
 tb/tb_pipe_skid_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: a generic pipeline stage register with a valid/ready
// handshake and a two-entry skid buffer. Because the buffer has a second
// slot, in_ready_o depends only on the registered state and the stall/bubble
// controls, and never on out_ready_i.
//
// main_q is the head entry and drives out_data_o directly. skid_q is the
// second entry. Each slot holds NOP_VALUE whenever it is empty.
//
// flush_i empties the stage and takes priority over hold_i. hold_i freezes
// all state.
//
// Optional feature, macro PIPE_STAGE_STATS_EN:
//   - When defined, the module has saturating counters for hold cycles and
//     flush events.
//   - When undefined, the two statistics ports are tied to zero.
module pipe_skid_stage #(
  parameter int                 DATA_W    = 76,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stat_hold_cnt_o,
  output logic [CNT_W-1:0]  stat_flush_cnt_o
);

  // The encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;
  assign out_data_o = main_q;

  // State and storage registers; reset clears both entries to the NOP payload.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and entry movement: flush beats hold, and hold beats any transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else if (!hold_i) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = FULL;
          end else if (out_fire) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready_o is low in FULL, so only a drain can happen here.
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // Handshake outputs; both are suppressed while a stall or a bubble is requested.
  always_comb begin
    in_ready_o  = (state_q != FULL) & ~hold_i & ~flush_i;
    out_valid_o = (state_q != EMPTY) & ~hold_i & ~flush_i;
    occupancy_o = state_q;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      hold_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (flush_i && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (hold_i && !flush_i && (hold_cnt_q != {CNT_W{1'b1}}))
        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
    end
  end

  assign stat_hold_cnt_o  = hold_cnt_q;
  assign stat_flush_cnt_o = flush_cnt_q;
`else
  assign stat_hold_cnt_o  = '0;
  assign stat_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and random traffic.
module tb_pipe_skid_stage;

  localparam int          DW  = 16;
  localparam int          CW  = 4;
  localparam logic [15:0] NOP = 16'hBEEF;

  logic          dclk = 1'b0;
  logic          rst;
  logic          flush_i, hold_i, in_valid_i, out_ready_i;
  logic [DW-1:0] in_data_i;
  logic          in_ready_o, out_valid_o;
  logic [DW-1:0] out_data_o;
  logic [1:0]    occupancy_o;
  logic [CW-1:0] stat_hold_cnt_o, stat_flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Model: queue of held payloads plus saturating counters.
  logic [DW-1:0] mq[$];
  int            m_hold  = 0;
  int            m_flush = 0;

  pipe_skid_stage #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
    .dclk(dclk), .rst(rst), .flush_i(flush_i), .hold_i(hold_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .occupancy_o(occupancy_o), .stat_hold_cnt_o(stat_hold_cnt_o),
    .stat_flush_cnt_o(stat_flush_cnt_o)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef PIPE_STAGE_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  // Compare all DUT outputs against the model for the current inputs.
  task automatic compare();
    logic          e_rdy, e_vld;
    logic [DW-1:0] e_dat;
    e_rdy = (mq.size() < 2) && !hold_i && !flush_i;
    e_vld = (mq.size() > 0) && !hold_i && !flush_i;
    e_dat = (mq.size() > 0) ? mq[0] : NOP;
    chk("in_ready", 32'(in_ready_o), 32'(e_rdy));
    chk("out_valid", 32'(out_valid_o), 32'(e_vld));
    chk("out_data", 32'(out_data_o), 32'(e_dat));
    chk("occupancy", 32'(occupancy_o), 32'(mq.size()));
    chk("hold_cnt", 32'(stat_hold_cnt_o), 32'(exp_cnt(m_hold)));
    chk("flush_cnt", 32'(stat_flush_cnt_o), 32'(exp_cnt(m_flush)));
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    logic rdy, vld, ifire, ofire;
    if (flush_i) begin
      mq.delete();
      if (m_flush < 15) m_flush++;
    end else if (hold_i) begin
      if (m_hold < 15) m_hold++;
    end else begin
      rdy   = mq.size() < 2;
      vld   = mq.size() > 0;
      ifire = in_valid_i && rdy;
      ofire = vld && out_ready_i;
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(in_data_i);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then update the model.
  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                     input logic ih, input logic ifl);
    @(negedge dclk);
    in_valid_i  = iv;
    in_data_i   = id;
    out_ready_i = ordy;
    hold_i      = ih;
    flush_i     = ifl;
    #1;
    compare();
    model_edge();
  endtask

  task automatic after_edge();
    @(posedge dclk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 0; hold_i = 0; in_valid_i = 0; out_ready_i = 0; in_data_i = '0;
    #2;
    chk("reset_valid", 32'(out_valid_o), 32'd0);
    chk("reset_data", 32'(out_data_o), 32'(NOP));
    chk("reset_occ", 32'(occupancy_o), 32'd0);
    @(negedge dclk);
    rst = 1'b0;

    // Streaming at full throughput.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      after_edge();
      chk("stream_data", 32'(out_data_o), 32'(i));
      chk("stream_occ", 32'(occupancy_o), 32'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure fills the skid slot, then drains in order.
    cyc(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("bp_occ", 32'(occupancy_o), 32'd2);
    chk("bp_ready", 32'(in_ready_o), 32'd0);
    cyc(1'b1, 16'h00A3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A3, 1'b1, 1'b0, 1'b0);
    chk("bp_first", 32'(out_data_o), 32'h00A1);
    after_edge();
    chk("bp_second", 32'(out_data_o), 32'h00A2);
    cyc(1'b1, 16'h00A3, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("bp_third", 32'(out_data_o), 32'h00A3);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Hold with one entry held.
    cyc(1'b1, 16'h003C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0055, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("hold_valid", 32'(out_valid_o), 32'd0);
    chk("hold_data", 32'(out_data_o), 32'h003C);
    chk("hold_cnt3", 32'(stat_hold_cnt_o), 32'(exp_cnt(3)));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("hold_release_valid", 32'(out_valid_o), 32'd1);
    chk("hold_release_data", 32'(out_data_o), 32'h003C);

    // Flush together with hold at occupancy 2.
    cyc(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0067, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0077, 1'b0, 1'b1, 1'b1);
    after_edge();
    chk("flush_occ", 32'(occupancy_o), 32'd0);
    chk("flush_data", 32'(out_data_o), 32'(NOP));
    chk("flush_cnt1", 32'(stat_flush_cnt_o), 32'(exp_cnt(1)));
    chk("flush_holdcnt", 32'(stat_hold_cnt_o), 32'(exp_cnt(3)));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Counter saturation.
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("hold_sat", 32'(stat_hold_cnt_o), 32'(exp_cnt(15)));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset mid-stream at occupancy 2.
    cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("pre_rst_occ", 32'(occupancy_o), 32'd2);
    #1;
    in_valid_i = 0; out_ready_i = 1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_data", 32'(out_data_o), 32'(NOP));
    chk("midrst_occ", 32'(occupancy_o), 32'd0);
    chk("midrst_hold", 32'(stat_hold_cnt_o), 32'd0);
    mq.delete();
    m_hold = 0;
    m_flush = 0;
    @(negedge dclk);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
